alu_wb_buffer: RTL and testbench
================================

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter XLEN, default 32, data width of ALU results and register-file write data.
REQ-002 Parameter DEPTH, default 4, number of buffered result entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 in_valid  input  1  ALU array presents a result this cycle.
REQ-006 in_rd  input  5  destination register of the presented result.
REQ-007 in_result  input  XLEN  result word from the ALU array.
REQ-008 in_ready  output  1  buffer accepts the presented result this cycle.
REQ-009 flush  input  1  discard all buffered results.
REQ-010 rf_busy  input  1  register-file write port unavailable this cycle.
REQ-011 reg_we  output  1  register-file write enable.
REQ-012 reg_wa  output  5  register-file write address.
REQ-013 reg_wd  output  XLEN  register-file write data.
REQ-014 fwd_addr1, fwd_addr2  input  5 each  source-register lookup addresses from issue.
REQ-015 fwd_hit1, fwd_hit2  output  1 each  a buffered entry matches the lookup address.
REQ-016 fwd_data1, fwd_data2  output  XLEN each  data of the youngest matching entry.
REQ-017 count  output  clog2(DEPTH+1)  number of valid entries.

Function
REQ-018 Buffer is a circular FIFO of {rd, result} entries with head and tail pointers that wrap modulo DEPTH.
REQ-019 in_ready is high when count < DEPTH and reset and flush are low; no same-cycle pass-through when full.
REQ-020 Push occurs when in_valid and in_ready are high and in_rd != 0; the entry is written at tail and visible from the next cycle.
REQ-021 A handshake with in_rd == 0 completes but enqueues nothing (x0 writes dropped).
REQ-022 reg_we is high when count > 0 and rf_busy is low; reg_wa/reg_wd carry the head entry combinationally.
REQ-023 Pop occurs on every cycle reg_we is high; head advances one entry.
REQ-024 When reg_we is low, reg_wa and reg_wd are driven to 0.
REQ-025 Simultaneous push and pop leave count unchanged; a full buffer does not accept a push in the cycle it pops.
REQ-026 flush has priority over push and pop: reg_we is forced low in the flush cycle and count is 0 on the next cycle.
REQ-027 Forwarding lookup is combinational over valid stored entries, including the entry being popped this cycle; an in-flight push is not searched.
REQ-028 fwd_hitN is low when fwd_addrN == 0; on multiple matches fwd_dataN is the youngest (closest to tail) entry; fwd_dataN is 0 on miss.
REQ-029 Write-back order equals acceptance order; latency from accept to reg_we is one cycle with an empty buffer and rf_busy low.

Reset
REQ-030 While reset is high at a clock edge: head, tail and count are cleared to 0, all entries invalidated.
REQ-031 During and after reset until the first push: reg_we = 0, reg_wa = 0, reg_wd = 0, in_ready = 0 while reset high then 1, fwd_hit1/2 = 0, count = 0.
REQ-032 Reset asserted mid-operation discards all pending entries; no register write occurs in the reset cycle.

Structure
REQ-033 XLEN default, register-address width (5) and the entry record type belong in the shared core package.
REQ-034 One sub-module is natural: alu_wb_fwd_match, the youngest-match priority search, instanced twice.

Verification
REQ-035 Single push rd=5, result=0x0000_00A5, rf_busy=0 -> next cycle reg_we=1, reg_wa=5, reg_wd=0x0000_00A5, count=1, then count=0.
REQ-036 rf_busy=1, push rd=1..4 with data 0x11..0x44 -> count=4, in_ready=0; fifth push stalls; release rf_busy -> writes 1,2,3,4 in order on four consecutive cycles.
REQ-037 Push rd=0, result=0xDEAD_BEEF -> handshake completes, count stays 0, reg_we never asserts.
REQ-038 rf_busy=1, push rd=7 data 0x1 then rd=7 data 0x2; fwd_addr1=7 -> fwd_hit1=1, fwd_data1=0x2; fwd_addr2=0 -> fwd_hit2=0.
REQ-039 Buffer holding 3 entries, flush=1 with in_valid=1 -> no write that cycle, count=0 next cycle, incoming result not enqueued.
REQ-040 Continuous push/pop over 10 entries with rf_busy=0 -> count steady at 1, pointers wrap past DEPTH, all 10 results written in order.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU write-back buffer: widths and the buffered entry record.
package alu_wb_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned REG_AW   = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   // One buffered write-back: destination register plus result word (default width).
   typedef struct packed {
      reg_addr_t           rd;
      logic [XLEN_DEF-1:0] result;
   } wb_entry_t;

endpackage

// File: rtl/alu_wb_fwd_match.sv
// Youngest-match search over the valid window [head, head+count) of the write-back buffer.
module alu_wb_fwd_match
   import alu_wb_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic [REG_AW-1:0]                addr,
   input  logic [$clog2(DEPTH)-1:0]         head,
   input  logic [$clog2(DEPTH+1)-1:0]       count,
   input  logic [DEPTH-1:0][REG_AW-1:0]     rd_arr,
   input  logic [DEPTH-1:0][XLEN-1:0]       data_arr,
   output logic                             hit,
   output logic [XLEN-1:0]                  data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((CW'(k) < count) && (addr != '0) && (rd_arr[idx] == addr)) begin
            hit  = 1'b1;
            data = data_arr[idx];
         end
      end
   end

endmodule

// File: rtl/alu_wb_buffer.sv
// Circular FIFO between the ALU array and the register-file write port, with forwarding lookup.
module alu_wb_buffer
   import alu_wb_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [REG_AW-1:0]             in_rd,
   input  logic [XLEN-1:0]               in_result,
   output logic                          in_ready,
   input  logic                          flush,
   input  logic                          rf_busy,
   output logic                          reg_we,
   output logic [REG_AW-1:0]             reg_wa,
   output logic [XLEN-1:0]               reg_wd,
   input  logic [REG_AW-1:0]             fwd_addr1,
   input  logic [REG_AW-1:0]             fwd_addr2,
   output logic                          fwd_hit1,
   output logic                          fwd_hit2,
   output logic [XLEN-1:0]               fwd_data1,
   output logic [XLEN-1:0]               fwd_data2,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][REG_AW-1:0] rd_q;
   logic [DEPTH-1:0][XLEN-1:0]   data_q;
   logic [PW-1:0]                head_q, tail_q;
   logic [CW-1:0]                count_q;
   logic [CW-1:0]                fwd_count;
   logic                         push, pop;

   // Handshake, push/pop decode and head-entry write-back port.
   always_comb begin
      in_ready  = !reset && !flush && (count_q < CW'(DEPTH));
      push      = in_valid && in_ready && (in_rd != '0);
      reg_we    = (count_q != '0) && !rf_busy && !flush && !reset;
      pop       = reg_we;
      reg_wa    = reg_we ? rd_q[head_q] : '0;
      reg_wd    = reg_we ? data_q[head_q] : '0;
      // Hide stale contents from lookups while reset is held.
      fwd_count = reset ? '0 : count_q;
   end

   assign count = count_q;

   // Entry storage; contents only matter inside the valid window, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[tail_q]   <= in_rd;
         data_q[tail_q] <= in_result;
      end
   end

   // Pointers and occupancy; reset and flush empty the buffer.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   alu_wb_fwd_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_match1 (
      .addr     (fwd_addr1),
      .head     (head_q),
      .count    (fwd_count),
      .rd_arr   (rd_q),
      .data_arr (data_q),
      .hit      (fwd_hit1),
      .data     (fwd_data1)
   );

   alu_wb_fwd_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_match2 (
      .addr     (fwd_addr2),
      .head     (head_q),
      .count    (fwd_count),
      .rd_arr   (rd_q),
      .data_arr (data_q),
      .hit      (fwd_hit2),
      .data     (fwd_data2)
   );

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer (XLEN=32, DEPTH=4).
module tb_alu_wb_buffer;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, rf_busy, reg_we;
   logic [4:0]  in_rd, reg_wa, fwd_addr1, fwd_addr2;
   logic [31:0] in_result, reg_wd, fwd_data1, fwd_data2;
   logic        fwd_hit1, fwd_hit2;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   alu_wb_buffer #(
      .XLEN  (32),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_rd     (in_rd),
      .in_result (in_result),
      .in_ready  (in_ready),
      .flush     (flush),
      .rf_busy   (rf_busy),
      .reg_we    (reg_we),
      .reg_wa    (reg_wa),
      .reg_wd    (reg_wd),
      .fwd_addr1 (fwd_addr1),
      .fwd_addr2 (fwd_addr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change at +1, checks at +2.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_busy(input logic [4:0] rd, input logic [31:0] d);
      in_valid  = 1'b1;
      in_rd     = rd;
      in_result = d;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0;
      flush = 1'b0; rf_busy = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
      tick();
      tick();
      #1;
      // Reset state while reset still high
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_reg_we", reg_we, 0);
      check_eq("rst_count", count, 0);
      fwd_addr1 = 5'd5; fwd_addr2 = 5'd1;
      #1;
      check_eq("rst_fwd_hit1", fwd_hit1, 0);
      check_eq("rst_fwd_hit2", fwd_hit2, 0);
      reset = 1'b0;
      #1;
      check_eq("post_rst_in_ready", in_ready, 1);
      check_eq("post_rst_wa", reg_wa, 0);
      check_eq("post_rst_wd", reg_wd, 0);

      // Single push, one-cycle latency
      tick();
      in_valid = 1'b1; in_rd = 5'd5; in_result = 32'h0000_00A5;
      #1;
      check_eq("single_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("single_we", reg_we, 1);
      check_eq("single_wa", reg_wa, 5);
      check_eq("single_wd", reg_wd, 32'hA5);
      check_eq("single_count1", count, 1);
      tick();
      #1;
      check_eq("single_count0", count, 0);
      check_eq("single_we_off", reg_we, 0);
      check_eq("single_wa_off", reg_wa, 0);

      // Fill while register file is busy, then drain in order
      rf_busy = 1'b1;
      for (int i = 1; i <= 4; i++) push_busy(5'(i), 32'(i * 'h11));
      #1;
      check_eq("full_count", count, 4);
      check_eq("full_ready", in_ready, 0);
      check_eq("full_we", reg_we, 0);
      in_valid = 1'b1; in_rd = 5'd9; in_result = 32'h99;
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("stall_count", count, 4);
      rf_busy = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check_eq($sformatf("drain_we%0d", i), reg_we, 1);
         check_eq($sformatf("drain_wa%0d", i), reg_wa, 64'(i));
         check_eq($sformatf("drain_wd%0d", i), reg_wd, 64'(i * 'h11));
         tick();
      end
      #1;
      check_eq("drain_empty", count, 0);

      // x0 write is accepted but dropped
      in_valid = 1'b1; in_rd = 5'd0; in_result = 32'hDEAD_BEEF;
      #1;
      check_eq("x0_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("x0_count", count, 0);
      check_eq("x0_we", reg_we, 0);
      tick();
      #1;
      check_eq("x0_we_later", reg_we, 0);

      // Forwarding picks the youngest match
      rf_busy = 1'b1;
      push_busy(5'd7, 32'h1);
      push_busy(5'd7, 32'h2);
      fwd_addr1 = 5'd7; fwd_addr2 = 5'd0;
      #1;
      check_eq("fwd_hit1", fwd_hit1, 1);
      check_eq("fwd_data1", fwd_data1, 2);
      check_eq("fwd_hit2", fwd_hit2, 0);
      check_eq("fwd_data2", fwd_data2, 0);
      fwd_addr2 = 5'd3;
      #1;
      check_eq("fwd_miss_hit", fwd_hit2, 0);
      // Popping entry remains visible this cycle
      rf_busy = 1'b0;
      #1;
      check_eq("fwd_pop_hit", fwd_hit1, 1);
      check_eq("fwd_pop_data", fwd_data1, 2);
      tick();
      tick();
      #1;
      check_eq("fwd_drained", count, 0);
      check_eq("fwd_empty_hit", fwd_hit1, 0);

      // Flush beats push and pop
      rf_busy = 1'b1;
      for (int i = 1; i <= 3; i++) push_busy(5'(i), 32'(i));
      rf_busy = 1'b0; flush = 1'b1;
      in_valid = 1'b1; in_rd = 5'd10; in_result = 32'hAA;
      #1;
      check_eq("flush_we", reg_we, 0);
      check_eq("flush_ready", in_ready, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("flush_count", count, 0);
      check_eq("flush_we_next", reg_we, 0);

      // Streaming through pointer wrap
      for (int i = 0; i <= 10; i++) begin
         in_valid  = (i < 10);
         in_rd     = 5'(i + 1);
         in_result = 32'h100 + 32'(i);
         #1;
         if (i > 0) begin
            check_eq($sformatf("stream_count%0d", i), count, 1);
            check_eq($sformatf("stream_we%0d", i), reg_we, 1);
            check_eq($sformatf("stream_wa%0d", i), reg_wa, 64'(i));
            check_eq($sformatf("stream_wd%0d", i), reg_wd, 64'(32'h100 + 32'(i - 1)));
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      check_eq("stream_done", count, 0);

      // Reset mid-operation discards entries with no write
      rf_busy = 1'b1;
      push_busy(5'd3, 32'h33);
      push_busy(5'd4, 32'h44);
      rf_busy = 1'b0; reset = 1'b1;
      #1;
      check_eq("midrst_we", reg_we, 0);
      tick();
      reset = 1'b0;
      #1;
      check_eq("midrst_count", count, 0);
      check_eq("midrst_we_after", reg_we, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
